// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounces start/stop, lap and clear buttons and sequences the counter.
// Optional build macro STOPWATCH_AUTOSTOP_EN freezes the counter into PAUSE at 59:59.
//
// state    | meaning
// IDLE     | counter held, waiting for first start
// RUN      | counter running, display live
// PAUSE    | counter held, display live
// LAP_HOLD | counter running, display frozen on lap register
module stopwatch_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clr,
   input  logic [5:0] seconds,
   input  logic [5:0] minutes,
   output logic       cnt_stop,
   output logic       cnt_clear,
   output logic [5:0] disp_seconds,
   output logic [5:0] disp_minutes,
   output logic [3:0] lap_count,
   output logic [1:0] state_o
);

   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_LAP   = 2'd3
   } state_t;

   logic [2:0]       w_btn;
   logic [2:0]       r_sync0;
   logic [2:0]       r_sync1;
   logic [2:0]       r_acc;
   logic [2:0]       r_acc_d;
   logic [2:0]       r_pulse;
   logic [CNT_W-1:0] r_cnt [3];

   assign w_btn = {btn_clr, btn_lap, btn_start};

   // Counter restarts when the level about to enter r_sync1 differs from it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync0 <= '0;
         r_sync1 <= '0;
         r_acc   <= '0;
         r_acc_d <= '0;
         r_pulse <= '0;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_sync0 <= w_btn;
         r_sync1 <= r_sync0;
         r_acc_d <= r_acc;
         r_pulse <= r_acc & ~r_acc_d;
         for (int i = 0; i < 3; i++) begin
            if (r_sync0[i] != r_sync1[i])
               r_cnt[i] <= '0;
            else if (r_cnt[i] != LP_CNT_MAX)
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            if (r_cnt[i] == LP_CNT_MAX)
               r_acc[i] <= r_sync1[i];
         end
      end
   end

   logic w_clr_p;
   logic w_start_p;
   logic w_lap_p;
   logic w_autostop;

   assign w_clr_p   = r_pulse[2];
   assign w_start_p = r_pulse[0] & ~r_pulse[2];
   assign w_lap_p   = r_pulse[1] & ~r_pulse[0] & ~r_pulse[2];

`ifdef STOPWATCH_AUTOSTOP_EN
   logic w_at_max;
   assign w_at_max   = (seconds == 6'd59) && (minutes == 6'd59);
   assign w_autostop = w_at_max & ~w_clr_p;
`else
   assign w_autostop = 1'b0;
`endif

   state_t     r_state;
   logic [5:0] r_lap_s;
   logic [5:0] r_lap_m;

   // Display and cnt_stop follow the state being entered on this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         cnt_stop     <= 1'b1;
         cnt_clear    <= 1'b0;
         disp_seconds <= '0;
         disp_minutes <= '0;
         lap_count    <= '0;
         r_lap_s      <= '0;
         r_lap_m      <= '0;
      end else begin
         cnt_clear    <= 1'b0;
         disp_seconds <= seconds;
         disp_minutes <= minutes;
         case (r_state)
            S_IDLE: begin
               if (w_clr_p) begin
                  cnt_clear <= 1'b1;
                  lap_count <= '0;
               end else if (w_start_p) begin
                  r_state  <= S_RUN;
                  cnt_stop <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_autostop || w_start_p) begin
                  r_state  <= S_PAUSE;
                  cnt_stop <= 1'b1;
               end else if (w_lap_p) begin
                  r_state <= S_LAP;
                  r_lap_s <= seconds;
                  r_lap_m <= minutes;
                  if (lap_count != 4'd15) lap_count <= lap_count + 4'd1;
               end
            end
            S_PAUSE: begin
               if (w_clr_p) begin
                  r_state   <= S_IDLE;
                  cnt_clear <= 1'b1;
                  lap_count <= '0;
               end else if (w_start_p) begin
                  r_state  <= S_RUN;
                  cnt_stop <= 1'b0;
               end
            end
            S_LAP: begin
               if (w_autostop || w_start_p) begin
                  r_state  <= S_PAUSE;
                  cnt_stop <= 1'b1;
               end else if (w_lap_p) begin
                  r_state <= S_RUN;
               end else begin
                  disp_seconds <= r_lap_s;
                  disp_minutes <= r_lap_m;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               cnt_stop <= 1'b1;
            end
         endcase
      end
   end

   assign state_o = r_state;

endmodule
